// File: rtl/dmem_pkg.sv
// Shared constants, FSM state encodings and parity helper for the dmem_ctrl data memory.
package dmem_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 256;
    localparam int unsigned PAR_MAX_W  = 64;

    typedef logic [1:0] state_t;
    localparam state_t ST_CLEAR = 2'd0;
    localparam state_t ST_IDLE  = 2'd1;
    localparam state_t ST_DUMP  = 2'd2;

    // Even parity over a zero-extended word; callers pass at most PAR_MAX_W bits.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with one synchronous write port and one registered, write-first read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned WORD_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: post-reset clear, registered access port and word-per-cycle dump streamer.
// Optional macro DMEM_PARITY_EN adds a stored even-parity bit, par_inj input and par_err output.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data,
    output logic              rd_valid,
    output logic              addr_err,
    output logic              busy,
    input  logic              p_en,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
`ifdef DMEM_PARITY_EN
   ,input  logic              par_inj,
    output logic              par_err
`endif
);

`ifdef DMEM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_C  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W:0]   cnt;
    logic              p_en_q;
    logic              rd_hit_q;
    logic              rd_valid_q;
    logic              addr_err_q;
    logic              dump_valid_q;
    logic              dump_done_q;
    logic [ADDR_W-1:0] dump_addr_q;

    logic              in_range;
    logic              p_edge;
    logic [WORD_W-1:0] acc_word;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [WORD_W-1:0] arr_wdata;
    logic [ADDR_W-1:0] arr_raddr;
    logic [WORD_W-1:0] rdata;

    assign in_range = ({1'b0, address} < DEPTH_C);
    assign p_edge   = p_en & ~p_en_q;
    assign busy     = (state != ST_IDLE);

`ifdef DMEM_PARITY_EN
    assign acc_word = {even_parity(PAR_MAX_W'(in_data)) ^ par_inj, in_data};
`else
    assign acc_word = in_data;
`endif

    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = address;
        arr_wdata = acc_word;
        arr_raddr = address;
        case (state)
            ST_CLEAR: begin
                arr_we    = 1'b1;
                arr_waddr = cnt[ADDR_W-1:0];
                arr_wdata = '0;
            end
            ST_IDLE:  arr_we    = w_en & in_range;
            ST_DUMP:  arr_raddr = cnt[ADDR_W-1:0];
            default:  ;
        endcase
    end

    dmem_array #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (arr_raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_CLEAR;
            cnt          <= '0;
            p_en_q       <= 1'b0;
            rd_hit_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            addr_err_q   <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
            dump_addr_q  <= '0;
        end else begin
            p_en_q      <= p_en;
            rd_hit_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            dump_done_q <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (cnt == LAST_C) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    rd_valid_q <= en;
                    rd_hit_q   <= en & in_range;
                    addr_err_q <= (en | w_en) & ~in_range;
                    if (p_edge) begin
                        state <= ST_DUMP;
                        cnt   <= '0;
                    end
                end
                ST_DUMP: begin
                    // Read data lags the issued address by one cycle, so the
                    // stream ends once the last word has been presented.
                    if (dump_valid_q && (dump_addr_q == LAST_A)) begin
                        dump_valid_q <= 1'b0;
                        dump_done_q  <= 1'b1;
                        dump_addr_q  <= '0;
                        state        <= ST_IDLE;
                        cnt          <= '0;
                    end else begin
                        dump_valid_q <= 1'b1;
                        dump_addr_q  <= cnt[ADDR_W-1:0];
                        cnt          <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign out_data   = rd_hit_q ? rdata[DATA_W-1:0] : '0;
    assign rd_valid   = rd_valid_q;
    assign addr_err   = addr_err_q;
    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = dump_valid_q ? rdata[DATA_W-1:0] : '0;
    assign dump_done  = dump_done_q;

`ifdef DMEM_PARITY_EN
    assign par_err = (rd_hit_q | dump_valid_q) & (^rdata);
`endif

endmodule
